// File: rtl/job_scheduler_pkg.sv
// rtl/job_scheduler_pkg.sv - viewport geometry, job record and scheduler state types
package job_scheduler_pkg;

  localparam int JOBS             = 640;
  localparam int JOBS_SUBDIVISION = 64;
  localparam int VIEW_H           = 480;
  localparam int PX_X_B           = $clog2(JOBS);
  localparam int PX_Y_B           = $clog2(VIEW_H);

  typedef struct packed {
    logic [PX_X_B-1:0] x;
    logic [PX_Y_B-1:0] y;
  } Job;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N  = 10,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          ci;
  logic [IW-1:0] c;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    ci     = 0;
    c      = '0;
    for (int k = 0; k < N; k++) begin
      ci = int'(ptr) + k;
      if (ci >= N) ci = ci - N;
      c = IW'(ci);
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = c;
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_scheduler.sv
// rtl/job_scheduler.sv - splits each frame into scanline jobs and deals them to workers round-robin
module job_scheduler
  import job_scheduler_pkg::*;
#(
  parameter int N_WORKERS = 10,
  parameter int JOB_W     = JOBS_SUBDIVISION,
  parameter int WIDTH     = JOBS,
  parameter int HEIGHT    = VIEW_H
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_start,
  input  logic [N_WORKERS-1:0] req,
  input  logic [N_WORKERS-1:0] done,
  output logic [N_WORKERS-1:0] grant,
  output logic [PX_X_B-1:0]    job_x,
  output logic [PX_Y_B-1:0]    job_y,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int XJOBS = WIDTH / JOB_W;
  localparam int XW    = (XJOBS > 1) ? $clog2(XJOBS) : 1;
  localparam int PW    = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;

  sched_state_t         state;
  logic [N_WORKERS-1:0] worker_busy;
  logic [PW-1:0]        rr_ptr;
  logic [XW-1:0]        x_idx;
  logic [PX_Y_B-1:0]    y_idx;

  logic [N_WORKERS-1:0] eligible;
  logic [N_WORKERS-1:0] arb_onehot;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;
  logic [N_WORKERS-1:0] busy_after_done;
  logic                 last_job;
  Job                   next_job;

  // done only clears a bit that is set, so stray pulses to idle workers vanish here
  assign busy_after_done = worker_busy & ~done;
  assign eligible        = (state == S_DISPATCH) ? (req & ~worker_busy) : '0;
  assign last_job        = (x_idx == XW'(XJOBS - 1)) && (y_idx == PX_Y_B'(HEIGHT - 1));

  always_comb begin
    next_job   = '0;
    next_job.x = PX_X_B'(x_idx) << $clog2(JOB_W);
    next_job.y = y_idx;
  end

  rr_arbiter #(.N(N_WORKERS), .IW(PW)) u_arb (
    .req    (eligible),
    .ptr    (rr_ptr),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      worker_busy <= '0;
      rr_ptr      <= '0;
      x_idx       <= '0;
      y_idx       <= '0;
      grant       <= '0;
      job_x       <= '0;
      job_y       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      grant      <= '0;
      job_x      <= '0;
      job_y      <= '0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state       <= S_DISPATCH;
            x_idx       <= '0;
            y_idx       <= '0;
            worker_busy <= '0;
            busy        <= 1'b1;
          end
        end
        S_DISPATCH: begin
          worker_busy <= busy_after_done | arb_onehot;
          if (arb_any) begin
            grant  <= arb_onehot;
            job_x  <= next_job.x;
            job_y  <= next_job.y;
            rr_ptr <= (arb_idx == PW'(N_WORKERS - 1)) ? '0 : arb_idx + PW'(1);
            if (x_idx == XW'(XJOBS - 1)) begin
              x_idx <= '0;
              y_idx <= y_idx + PX_Y_B'(1);
            end else begin
              x_idx <= x_idx + XW'(1);
            end
            if (last_job) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          worker_busy <= busy_after_done;
          if (busy_after_done == '0) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_job_scheduler.sv
// tb/tb_job_scheduler.sv - directed vector table plus full-frame worker model for job_scheduler
module tb_job_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       frame_start;
  logic [9:0] req;
  logic [9:0] done;
  logic [9:0] grant;
  logic [9:0] job_x;
  logic [8:0] job_y;
  logic       busy;
  logic       frame_done;

  job_scheduler dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .job_x       (job_x),
    .job_y       (job_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fs;
    logic [9:0] req;
    logic [9:0] done;
    logic [9:0] g;
    logic [9:0] x;
    logic [8:0] y;
    logic       b;
    logic       fd;
  } vec_t;

  vec_t tbl[$];
  int   tests  = 0;
  int   failed = 0;

  int   jobs, ex, ey, fd_seen, last_done_cyc, spur;
  int   cnt [10];
  logic prev_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; frame_start = 1'b0; req = '0; done = '0;
    repeat (2) step();
    chk("reset_outputs", {grant, job_x, job_y, busy, frame_done}, '0);
    rstn = 1'b1;

    // idle ignores req, then frame start, then ten grants w0..w9
    tbl.push_back('{1'b0, 10'h3FF, 10'h0, 10'h0, 10'd0, 9'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 10'h000, 10'h0, 10'h0, 10'd0, 9'd0, 1'b1, 1'b0});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{1'b0, 10'h3FF, 10'h0, 10'(1 << k), 10'(k * 64), 9'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h3FF, 10'h0, 10'h0, 10'd0, 9'd0, 1'b1, 1'b0});
    // done[3] with req held: regrant exactly one cycle later, next scanline
    tbl.push_back('{1'b0, 10'h3FF, 10'h008, 10'h0, 10'd0, 9'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h3FF, 10'h000, 10'h008, 10'd0, 9'd1, 1'b1, 1'b0});
    // steer rr_ptr to 3 by granting w2, then w2/w5 requesting together
    tbl.push_back('{1'b0, 10'h000, 10'h004, 10'h0, 10'd0, 9'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h004, 10'h000, 10'h004, 10'd64, 9'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h000, 10'h024, 10'h0, 10'd0, 9'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h024, 10'h000, 10'h020, 10'd128, 9'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h024, 10'h000, 10'h004, 10'd192, 9'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 10'h024, 10'h000, 10'h0, 10'd0, 9'd0, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      frame_start = tbl[i].fs; req = tbl[i].req; done = tbl[i].done;
      step();
      chk($sformatf("vec%0d", i), {grant, job_x, job_y, busy, frame_done},
          {tbl[i].g, tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].fd});
    end

    // one-cycle reset mid-dispatch abandons the frame
    rstn = 1'b0; frame_start = 1'b0; req = 10'h3FF; done = '0;
    step();
    chk("midframe_reset", {grant, job_x, job_y, busy, frame_done}, '0);
    rstn = 1'b1;
    repeat (3) begin
      step();
      chk("idle_after_reset", {grant, busy, frame_done}, '0);
    end

    // full frame: each worker pulses done five cycles after its grant
    jobs = 0; ex = 0; ey = 0; fd_seen = 0; last_done_cyc = -1; spur = 0;
    foreach (cnt[i]) cnt[i] = 0;
    req = 10'h3FF; frame_start = 1'b1;
    step();
    chk("frame_busy", {31'd0, busy}, 64'd1);
    for (int cyc = 0; cyc < 20000 && fd_seen == 0; cyc++) begin
      done = '0;
      frame_start = (cyc == 50 || cyc == 300);
      for (int i = 0; i < 10; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            done[i] = 1'b1; req[i] = 1'b1; last_done_cyc = cyc;
          end
        end
      end
      if (cyc == 100)
        for (int i = 0; i < 10; i++)
          if (spur == 0 && req[i] && !done[i]) begin done[i] = 1'b1; spur = 1; end
      prev_busy = busy;
      step();
      if (|grant) begin
        if (jobs == 0) chk("first_grant_w0", {54'd0, grant}, 64'd1);
        chk($sformatf("grant_job%0d", jobs),
            {jobs < 4800, $onehot(grant), (grant & ~req) == 10'd0, job_x, job_y},
            {1'b1, 1'b1, 1'b1, 10'(ex * 64), 9'(ey)});
        for (int i = 0; i < 10; i++)
          if (grant[i]) begin req[i] = 1'b0; cnt[i] = 5; end
        jobs++;
        ex++;
        if (ex == 10) begin ex = 0; ey++; end
      end else begin
        chk("idle_job_zero", {job_x, job_y}, '0);
      end
      if (frame_done) begin
        fd_seen++;
        chk("frame_done_timing", {cyc, busy, prev_busy, jobs},
            {last_done_cyc, 1'b0, 1'b1, 32'd4800});
      end else begin
        chk("busy_held", {63'd0, busy}, 64'd1);
      end
    end
    chk("frame_done_once", fd_seen, 1);
    chk("total_grants", jobs, 4800);

    // frame_start coinciding with DONE is ignored
    frame_start = 1'b1; done = '0;
    step();
    chk("fs_in_done_ignored", {grant, busy, frame_done}, '0);
    frame_start = 1'b0;
    repeat (3) begin
      step();
      chk("stay_idle", {grant, busy, frame_done}, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
